// File: rtl/board_step_ctrl_pkg.sv
// Shared encodings for the board single-step controller: run-mode switch
// values, FSM states and the LED slice-select width helper.
package board_dbg_pkg;

  localparam logic [1:0] MODE_STEP  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_RUN   = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEP,
    ST_BURST,
    ST_RUN
  } state_e;

  function automatic int sel_width(input int data_w, input int led_w);
    int n;
    n = data_w / led_w;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_step_ctrl_if.sv
// Board-side signals of the step controller: button, switches, CPU debug
// inputs and the clock-enable / LED / status outputs.
interface board_step_ctrl_if
  import board_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LED_W  = 4
);
  localparam int SEL_W = sel_width(DATA_W, LED_W);

  logic              next;
  logic [1:0]        mode_sw;
  logic [SEL_W-1:0]  sel_sw;
  logic [DATA_W-1:0] show;
  logic              done;
  logic              cpu_en;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic [15:0]       step_cnt;

  modport master (
    output next, mode_sw, sel_sw, show, done,
    input  cpu_en, led, busy, step_cnt
  );

  modport slave (
    input  next, mode_sw, sel_sw, show, done,
    output cpu_en, led, busy, step_cnt
  );

endinterface

// File: rtl/board_step_ctrl_btn_debounce.sv
// Two-flop synchroniser plus level debouncer for the step button; tick marks
// each accepted 0->1 edge once the button has been seen released after reset.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic level,
  output logic tick
);

  localparam int CNT_W = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             tick_q, tick_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] arm_cnt_q, arm_cnt_d;

  always_comb begin
    level_d   = level_q;
    cnt_d     = '0;
    armed_d   = armed_q;
    arm_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_TC) level_d = sync2_q;
      else                 cnt_d   = cnt_q + 1'b1;
    end
    // A button held through reset must first be seen released (debounced)
    // before any press can produce a tick.
    if (!armed_q && !level_q && !sync2_q) begin
      if (arm_cnt_q == CNT_TC) armed_d   = 1'b1;
      else                     arm_cnt_d = arm_cnt_q + 1'b1;
    end
    tick_d = armed_q & level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      tick_q    <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      arm_cnt_q <= '0;
    end else begin
      sync1_q   <= sw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      tick_q    <= tick_d;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign level = level_q;
  assign tick  = tick_q;

endmodule

// File: rtl/board_step_ctrl.sv
// Button-driven CPU stepping controller: single step, fixed burst or free-run
// via a one-cycle clock enable, plus a registered LED view of the debug word.
//
//   state    | meaning
//   ST_IDLE  | waiting for a button tick, cpu_en low
//   ST_STEP  | one cpu_en pulse, then back to idle
//   ST_BURST | cpu_en every cycle until BURST_N pulses issued
//   ST_RUN   | cpu_en once per FREE_DIV cycles until tick or done
module board_step_ctrl
  import board_dbg_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LED_W     = 4,
  parameter int unsigned DB_CYCLES = 20'd1_000_000,
  parameter int          BURST_N   = 16,
  parameter int          FREE_DIV  = 50_000_000
) (
  input logic              clk,
  input logic              reset,
  board_step_ctrl_if.slave bus
);

  localparam int N_SLICE = DATA_W / LED_W;
  localparam int BW      = $clog2(BURST_N + 1);
  localparam int DW      = (FREE_DIV < 2) ? 1 : $clog2(FREE_DIV);
  localparam logic [BW-1:0] BURST_LD = BW'(BURST_N);
  localparam logic [DW-1:0] DIV_TC   = DW'(FREE_DIV - 1);

  state_e           state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             busy_q, busy_d;
  logic [15:0]      step_cnt_q, step_cnt_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [DW-1:0]    div_q, div_d;
  logic             btn_level, btn_tick, go;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (clk),
    .reset (reset),
    .sw    (bus.next),
    .level (btn_level),
    .tick  (btn_tick)
  );

  assign go = btn_tick & btn_level & ~bus.done;

  // cpu_en_d is the pulse for the cycle the FSM moves into, so done or a
  // stopping tick seen at this edge suppresses the pulse that would follow.
  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    burst_d  = burst_q;
    div_d    = div_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          case (bus.mode_sw)
            MODE_STEP: begin
              state_d  = ST_STEP;
              cpu_en_d = 1'b1;
            end
            MODE_BURST: begin
              state_d  = ST_BURST;
              cpu_en_d = 1'b1;
              burst_d  = BURST_LD;
            end
            MODE_RUN: begin
              state_d = ST_RUN;
              div_d   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_BURST: begin
        if (bus.done || burst_q <= BW'(1)) begin
          state_d = ST_IDLE;
          burst_d = '0;
        end else begin
          cpu_en_d = 1'b1;
          burst_d  = burst_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (bus.done || btn_tick) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_TC) begin
          div_d    = '0;
          cpu_en_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d     = (state_d == ST_BURST) || (state_d == ST_RUN);
    step_cnt_d = (cpu_en_d && step_cnt_q != 16'hFFFF) ? step_cnt_q + 16'd1 : step_cnt_q;

    led_d = '0;
    if (int'(bus.sel_sw) < N_SLICE) led_d = bus.show[int'(bus.sel_sw)*LED_W +: LED_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      step_cnt_q <= '0;
      led_q      <= '0;
      burst_q    <= '0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cpu_en_q   <= cpu_en_d;
      busy_q     <= busy_d;
      step_cnt_q <= step_cnt_d;
      led_q      <= led_d;
      burst_q    <= burst_d;
      div_q      <= div_d;
    end
  end

  assign bus.cpu_en   = cpu_en_q;
  assign bus.busy     = busy_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.led      = led_q;

endmodule

// File: tb/tb_board_step_ctrl.sv
// Bench for board_step_ctrl: directed scenarios plus randomized presses,
// every cycle compared against an event-level model of the stepping rules.
module tb_board_step_ctrl;

  localparam int DATA_W   = 32;
  localparam int LED_W    = 4;
  localparam int DB       = 4;
  localparam int BURST_N  = 3;
  localparam int FREE_DIV = 5;

  localparam int M_IDLE  = 0;
  localparam int M_STEP  = 1;
  localparam int M_BURST = 2;
  localparam int M_RUN   = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  board_step_ctrl_if #(.DATA_W(DATA_W), .LED_W(LED_W)) bus ();

  board_step_ctrl #(
    .DATA_W    (DATA_W),
    .LED_W     (LED_W),
    .DB_CYCLES (DB),
    .BURST_N   (BURST_N),
    .FREE_DIV  (FREE_DIV)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_chk, n_fail, edge_n, last_react;
  int          ticks[$];
  bit          rnd_on;
  int          m_st, m_entry;
  logic        m_en, m_busy;
  logic [15:0] m_cnt;
  logic [3:0]  m_led;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h want %0h", tag, edge_n, obs, exp);
    end
  endtask

  // Model: a press is seen by the controller at a known edge; burst and run
  // pulses are derived from the distance to the entry edge.
  task automatic model_edge();
    bit          tk;
    logic [31:0] sh;
    tk = 1'b0;
    while (ticks.size() > 0 && ticks[0] < edge_n) void'(ticks.pop_front());
    if (ticks.size() > 0 && ticks[0] == edge_n) begin
      tk = 1'b1;
      void'(ticks.pop_front());
    end
    if (!rst_n) begin
      m_st = M_IDLE; m_en = 1'b0; m_busy = 1'b0; m_cnt = '0; m_led = '0;
      ticks.delete();
      return;
    end
    sh    = bus.show >> (int'(bus.sel_sw) * LED_W);
    m_led = sh[3:0];
    m_en  = 1'b0;
    case (m_st)
      M_IDLE: begin
        if (tk && !bus.done) begin
          case (bus.mode_sw)
            2'd0: begin m_st = M_STEP;  m_en = 1'b1; end
            2'd1: begin m_st = M_BURST; m_en = 1'b1; m_entry = edge_n; end
            2'd2: begin m_st = M_RUN;   m_entry = edge_n; end
            default: ;
          endcase
        end
      end
      M_STEP: m_st = M_IDLE;
      M_BURST: begin
        if (bus.done || (edge_n - m_entry) >= BURST_N) m_st = M_IDLE;
        else m_en = 1'b1;
      end
      M_RUN: begin
        if (bus.done || tk) m_st = M_IDLE;
        else if ((edge_n - m_entry) % FREE_DIV == 0) m_en = 1'b1;
      end
      default: m_st = M_IDLE;
    endcase
    if (m_en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    m_busy = (m_st == M_BURST) || (m_st == M_RUN);
  endtask

  task automatic cycle();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    chk("cpu_en",   32'(bus.cpu_en),   32'(m_en));
    chk("busy",     32'(bus.busy),     32'(m_busy));
    chk("step_cnt", 32'(bus.step_cnt), 32'(m_cnt));
    chk("led",      32'(bus.led),      32'(m_led));
    if (rnd_on) begin
      bus.show   = $urandom;
      bus.sel_sw = 3'($urandom_range(0, 7));
      bus.done   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 15) == 0) bus.mode_sw = 2'($urandom_range(0, 3));
    end
  endtask

  // Controller reacts to a clean rising edge 2 sync + DB sample + 1 tick
  // register edges after the first edge that samples the held level.
  task automatic press(input bit bounce);
    if (bounce) begin
      bus.next = 1'b1; cycle();
      bus.next = 1'b0; cycle();
      bus.next = 1'b1; cycle();
      bus.next = 1'b0; cycle();
    end
    bus.next   = 1'b1;
    last_react = edge_n + 1 + DB + 2;
    ticks.push_back(last_react);
    repeat (DB + 6) cycle();
    bus.next = 1'b0;
    repeat (DB + 6) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int r;
    n_chk = 0; n_fail = 0; edge_n = 0; rnd_on = 1'b0;
    m_st = M_IDLE; m_entry = 0; m_en = 1'b0; m_busy = 1'b0; m_cnt = '0; m_led = '0;
    bus.next = 1'b0; bus.mode_sw = 2'd0; bus.sel_sw = '0; bus.show = '0; bus.done = 1'b0;

    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (10) cycle();

    // bouncing press, single step
    bus.mode_sw = 2'd0;
    press(1'b1);
    chk("bounce_step_cnt", 32'(bus.step_cnt), 32'd1);

    // burst of BURST_N
    bus.mode_sw = 2'd1;
    press(1'b0);
    chk("burst_step_cnt", 32'(bus.step_cnt), 32'd4);

    // LED slice sweep
    bus.show = 32'h8765_4321;
    for (int i = 0; i < 8; i++) begin
      bus.sel_sw = 3'(i);
      cycle();
      chk("led_sweep", 32'(bus.led), 32'(i + 1));
    end

    // free run started and stopped by two presses
    bus.mode_sw = 2'd2;
    press(1'b0);
    repeat (3) cycle();
    press(1'b0);
    chk("run_stopped_busy", 32'(bus.busy), 32'd0);

    // free run stopped by done at a wrap, presses ignored while done
    press(1'b0);
    r = last_react;
    while (edge_n < r + 14) cycle();
    bus.done = 1'b1;
    cycle();
    chk("done_wrap_en", 32'(bus.cpu_en), 32'd0);
    press(1'b0);
    bus.done = 1'b0;
    repeat (3) cycle();
    chk("done_idle_busy", 32'(bus.busy), 32'd0);

    // randomized presses, modes, done and LED inputs
    rnd_on = 1'b1;
    for (int ep = 0; ep < 30; ep++) begin
      bus.mode_sw = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 20)) cycle();
      press(1'b0);
    end
    rnd_on   = 1'b0;
    bus.done = 1'b1;
    cycle();
    bus.done = 1'b0;
    repeat (2) cycle();

    // reset mid-burst with the button held through reset release
    bus.mode_sw = 2'd1;
    bus.next    = 1'b1;
    r = edge_n + 1 + DB + 2;
    ticks.push_back(r);
    while (edge_n < r) cycle();
    chk("burst_pulse1", 32'(bus.cpu_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_en",   32'(bus.cpu_en),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_step_cnt", 32'(bus.step_cnt), 32'd0);
    chk("rst_led",      32'(bus.led),      32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (20) cycle();
    bus.next = 1'b0;
    repeat (16) cycle();
    bus.mode_sw = 2'd0;
    press(1'b0);
    chk("post_rst_step_cnt", 32'(bus.step_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/board_step_ctrl.md
BOARD_STEP_CTRL -- requirements
Module: board_step_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the CPU debug word being displayed.
REQ-002 Parameter LED_W, default 4, number of board LEDs; DATA_W SHALL be an integer multiple of LED_W.
REQ-003 Parameter DB_CYCLES, default 20'd1_000_000, consecutive stable clk cycles required to accept a button level.
REQ-004 Parameter BURST_N, default 16, CPU steps issued per burst.
REQ-005 Parameter FREE_DIV, default 50_000_000, clk cycles between steps in free-run mode (>=1).
REQ-006 clk  input  1  system clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 next  input  1  raw, bouncing, asynchronous step button.
REQ-009 mode_sw  input  2  run mode: 00 single-step, 01 burst, 10 free-run, 11 hold.
REQ-010 sel_sw  input  SEL_W = clog2(DATA_W/LED_W), min 1  LED slice select.
REQ-011 show  input  DATA_W  CPU debug word.
REQ-012 done  input  1  CPU halted flag.
REQ-013 cpu_en  output  1  one-clk-wide CPU clock-enable pulse, registered.
REQ-014 led  output  LED_W  selected slice of show, registered.
REQ-015 busy  output  1  high while in BURST or RUN.
REQ-016 step_cnt  output  16  number of cpu_en pulses issued since reset.

Function
REQ-017 next SHALL pass a 2-FF synchroniser, then a debouncer that updates its level only after DB_CYCLES consecutive equal samples; tick = 1-cycle pulse on the debounced 0->1 edge.
REQ-018 FSM states: IDLE, STEP, BURST, RUN; cpu_en SHALL be high only in cycles stated below.
REQ-019 IDLE: cpu_en=0; on tick with done=0, sample mode_sw: 00->STEP, 01->BURST (load burst counter with BURST_N), 10->RUN (clear divider), 11->stay IDLE.
REQ-020 STEP: cpu_en=1 for exactly one cycle, next state IDLE.
REQ-021 BURST: cpu_en=1 every cycle, counter decrements per pulse; after the BURST_N-th pulse go to IDLE (exactly BURST_N pulses, no more).
REQ-022 RUN: divider counts 0..FREE_DIV-1; cpu_en=1 in the cycle divider wraps to 0; first pulse FREE_DIV cycles after entry; a tick in RUN returns to IDLE with no pulse that cycle.
REQ-023 done=1 in BURST or RUN SHALL force IDLE next cycle and suppress cpu_en in that cycle; ticks SHALL be ignored while done=1.
REQ-024 mode_sw changes outside IDLE SHALL be ignored; ticks in STEP or BURST SHALL be ignored.
REQ-025 step_cnt SHALL increment with each cpu_en pulse and saturate at 16'hFFFF.
REQ-026 led SHALL equal show[sel_sw*LED_W +: LED_W] registered (1-cycle latency); sel_sw >= DATA_W/LED_W SHALL yield all zeros.
REQ-027 busy SHALL be registered and high exactly in BURST and RUN.

Reset
REQ-028 reset low SHALL asynchronously set: state IDLE, cpu_en=0, led=0, busy=0, step_cnt=0, debouncer level=0 with counter 0, synchroniser FFs 0, burst counter and divider 0.
REQ-029 reset asserted mid-BURST or mid-RUN SHALL drop cpu_en within the same cycle; no pulse SHALL issue on the first clk edge after release.
REQ-030 A button held through reset release SHALL NOT produce a tick until the debounced level has first been 0.

Structure
REQ-031 Package board_dbg_pkg SHALL hold the mode_sw encodings (MODE_STEP, MODE_BURST, MODE_RUN, MODE_HOLD) and the FSM state enum.
REQ-032 Synchroniser plus debouncer SHALL be a sub-module btn_debounce (params DB_CYCLES; ports clk, reset, sw, level, tick), instantiated once.
REQ-033 board_step_ctrl SHALL never gate or divide clk; the CPU steps only via cpu_en.

Verification (DB_CYCLES=4, BURST_N=3, FREE_DIV=5, DATA_W=32, LED_W=4)
REQ-034 Bouncing next (1,0,1,0, then 1 held 10 cycles), mode 00 -> exactly one cpu_en pulse, step_cnt=1.
REQ-035 Mode 01, one clean press -> 3 consecutive cpu_en pulses, busy high 3 cycles, step_cnt=3; second press during burst ignored.
REQ-036 Mode 10, press, wait 22 cycles, press -> pulses at entry+5, +10, +15, +20 only; busy falls after second tick.
REQ-037 Mode 10 running, done raised at a wrap cycle -> no pulse that cycle, IDLE next, presses ignored while done=1.
REQ-038 show=32'h8765_4321, sel_sw=0..7 -> led = 1,2,3,4,5,6,7,8, each one cycle after sel change.
REQ-039 reset pulsed low mid-burst (after pulse 1) -> cpu_en=0 immediately, all outputs 0, step_cnt=0 after release.
